// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipeline_hazard_ctrl.
//   master : the hazard controller (samples hazard info, drives stall/flush controls)
//   slave  : the pipeline datapath (drives hazard info, samples stall/flush controls)
// Hazard info : id_valid, id_rs, id_rt, ex_mem_read, ex_rt, ex_muldiv, ex_branch_taken, ex_jump
// Controls    : pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush,
//               md_start, md_busy, stall_cnt[CNT_W-1:0]
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             ex_muldiv;
    logic             ex_branch_taken;
    logic             ex_jump;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_flush;
    logic             md_start;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        input  id_valid, id_rs, id_rt, ex_mem_read, ex_rt, ex_muldiv, ex_branch_taken, ex_jump,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush, md_start, md_busy,
               stall_cnt
    );

    modport slave (
        output id_valid, id_rs, id_rt, ex_mem_read, ex_rt, ex_muldiv, ex_branch_taken, ex_jump,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush, md_start, md_busy,
               stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline.
// Detects load-use hazards, squashes wrong-path instructions on taken branches/jumps and
// freezes the front end for MD_LAT cycles while the mult/div unit runs. Keeps a saturating
// count of front-end stall cycles.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : hazard info in, stall/flush controls and stall_cnt out (see pipeline_hazard_ctrl_if)
module pipeline_hazard_ctrl #(
    parameter int unsigned MD_LAT = 8,   // legal 2..255
    parameter int unsigned CNT_W  = 16
) (
    input logic                    clk,
    input logic                    reset,
    pipeline_hazard_ctrl_if.master bus
);

    typedef enum logic [0:0] {StRun, StMdBusy} state_e;

    // The start cycle is the first frozen cycle, so MD_BUSY lasts MD_LAT-1 cycles.
    localparam logic [7:0] MdCntInit = 8'(MD_LAT - 2);

    state_e           state_q, state_d;
    logic [7:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush, md_start, md_busy;

    // $0 is hardwired zero, so a lw targeting it never creates a dependency.
    assign load_use = bus.id_valid & bus.ex_mem_read & (bus.ex_rt != 5'd0) &
                      ((bus.ex_rt == bus.id_rs) | (bus.ex_rt == bus.id_rt));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StRun;
            md_cnt_q    <= 8'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        md_cnt_d    = md_cnt_q;
        stall_cnt_d = stall_cnt_q;
        unique case (state_q)
            StRun: begin
                if (bus.ex_muldiv) begin
                    state_d  = StMdBusy;
                    md_cnt_d = MdCntInit;
                end
            end
            StMdBusy: begin
                if (md_cnt_q == 8'd0) begin
                    state_d = StRun;
                end else begin
                    md_cnt_d = md_cnt_q - 8'd1;
                end
            end
            default: state_d = StRun;
        endcase
        if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Mealy output logic
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        md_start    = 1'b0;
        md_busy     = 1'b0;
        if (reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (bus.ex_muldiv) begin
                        md_start    = 1'b1;
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_flush = 1'b1;
                    end else if (bus.ex_branch_taken || bus.ex_jump) begin
                        // Redirect target loads; squash IF and ID, load-use is moot.
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                StMdBusy: begin
                    md_busy = 1'b1;
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                    // Final cycle: result lands in EX/MEM and ID/EX takes a fresh instruction.
                    if (md_cnt_q == 8'd0) begin
                        idex_en = 1'b1;
                    end else begin
                        idex_en     = 1'b0;
                        exmem_flush = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_en     = idex_en;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_flush = exmem_flush;
    assign bus.md_start    = md_start;
    assign bus.md_busy     = md_busy;
    assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a CNT_W=16 and a CNT_W=4 instance see the
// same stimulus; both are compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned MdLat = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(16)) bus ();
    pipeline_hazard_ctrl_if #(.CNT_W(4))  bus4 ();

    assign bus4.id_valid        = bus.id_valid;
    assign bus4.id_rs           = bus.id_rs;
    assign bus4.id_rt           = bus.id_rt;
    assign bus4.ex_mem_read     = bus.ex_mem_read;
    assign bus4.ex_rt           = bus.ex_rt;
    assign bus4.ex_muldiv       = bus.ex_muldiv;
    assign bus4.ex_branch_taken = bus.ex_branch_taken;
    assign bus4.ex_jump         = bus.ex_jump;

    pipeline_hazard_ctrl #(.MD_LAT(MdLat), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    pipeline_hazard_ctrl #(.MD_LAT(MdLat), .CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model state: frozen cycles still to come after the start cycle, raw stall count.
    int m_busy_left = 0;
    int m_stall = 0;

    // Control vector order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush,
    //                        md_start, md_busy}
    localparam logic [7:0] CtlReset  = 8'b0011_1100;
    localparam logic [7:0] CtlIdle   = 8'b1101_0000;
    localparam logic [7:0] CtlSquash = 8'b1111_1000;
    localparam logic [7:0] CtlLdUse  = 8'b0001_1000;
    localparam logic [7:0] CtlMdGo   = 8'b0000_0110;

    function automatic logic [7:0] exp_ctrl();
        logic hz;
        hz = bus.id_valid && bus.ex_mem_read && bus.ex_rt != 0 &&
             (bus.ex_rt == bus.id_rs || bus.ex_rt == bus.id_rt);
        if (reset) return CtlReset;
        if (m_busy_left == 1) return 8'b0001_0001;
        if (m_busy_left > 1) return 8'b0000_0101;
        if (bus.ex_muldiv) return CtlMdGo;
        if (bus.ex_branch_taken || bus.ex_jump) return CtlSquash;
        if (hz) return CtlLdUse;
        return CtlIdle;
    endfunction

    function automatic logic [7:0] obs_ctrl();
        return {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
                bus.exmem_flush, bus.md_start, bus.md_busy};
    endfunction

    function automatic logic [15:0] sat16(int v);
        return (v > 65535) ? 16'hffff : 16'(v);
    endfunction

    function automatic logic [3:0] sat4(int v);
        return (v > 15) ? 4'hf : 4'(v);
    endfunction

    // Advance the model by one clock using the current inputs, then move past the edge.
    task automatic tick();
        logic [7:0] e;
        e = exp_ctrl();
        if (reset) begin
            m_busy_left = 0;
            m_stall = 0;
        end else begin
            if (!e[7]) m_stall++;
            if (m_busy_left > 0) m_busy_left--;
            else if (bus.ex_muldiv) m_busy_left = MdLat - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_valid = 1'b0; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
        bus.ex_mem_read = 1'b0; bus.ex_rt = 5'd0; bus.ex_muldiv = 1'b0;
        bus.ex_branch_taken = 1'b0; bus.ex_jump = 1'b0;
    endtask

    task automatic random_inputs();
        bus.id_valid = ($urandom_range(3) != 0);
        bus.id_rs = 5'($urandom_range(3));
        bus.id_rt = 5'($urandom_range(3));
        bus.ex_mem_read = $urandom_range(1) == 1;
        bus.ex_rt = 5'($urandom_range(3));
        bus.ex_muldiv = ($urandom_range(15) == 0);
        bus.ex_branch_taken = ($urandom_range(7) == 0);
        bus.ex_jump = ($urandom_range(15) == 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            random_inputs();
            #1;
            vectors++;
            if (obs_ctrl() !== CtlReset) begin
                miscompares++;
                $display("FAIL reset_ctrl cyc%0d: got %b want %b", i, obs_ctrl(), CtlReset);
            end
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        #1;
        vectors++;
        if (obs_ctrl() !== CtlIdle) begin
            miscompares++;
            $display("FAIL reset_release_ctrl: got %b want %b", obs_ctrl(), CtlIdle);
        end
        vectors++;
        if (bus.stall_cnt !== 16'd0 || bus4.stall_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_stall_cnt: got %0d/%0d want 0", bus.stall_cnt, bus4.stall_cnt);
        end
    endtask

    task automatic test_load_use();
        int s0;
        s0 = m_stall;
        bus.id_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd5; bus.id_rs = 5'd5;
        #1;
        vectors++;
        if (obs_ctrl() !== CtlLdUse) begin
            miscompares++;
            $display("FAIL load_use_ctrl: got %b want %b", obs_ctrl(), CtlLdUse);
        end
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (obs_ctrl() !== CtlIdle || bus.stall_cnt !== 16'(s0 + 1)) begin
            miscompares++;
            $display("FAIL load_use_after: got %b/%0d want %b/%0d", obs_ctrl(), bus.stall_cnt,
                     CtlIdle, s0 + 1);
        end
        // Same pattern on $0: no hazard.
        bus.id_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd0; bus.id_rs = 5'd0;
        bus.id_rt = 5'd0;
        #1;
        vectors++;
        if (obs_ctrl() !== CtlIdle) begin
            miscompares++;
            $display("FAIL load_use_r0: got %b want %b", obs_ctrl(), CtlIdle);
        end
        tick();
        vectors++;
        if (bus.stall_cnt !== 16'(s0 + 1)) begin
            miscompares++;
            $display("FAIL load_use_r0_cnt: got %0d want %0d", bus.stall_cnt, s0 + 1);
        end
        idle_inputs();
    endtask

    task automatic test_muldiv();
        int s0, n_pc_low, n_busy, n_start;
        s0 = m_stall; n_pc_low = 0; n_busy = 0; n_start = 0;
        for (int i = 0; i < 14; i++) begin
            idle_inputs();
            bus.ex_muldiv = (i == 0);
            // Hazard inputs during MD_BUSY must be ignored.
            if (i > 0 && i < 7) begin
                bus.ex_branch_taken = 1'b1;
                bus.ex_muldiv = 1'b1;
            end
            if (i >= 7) bus.ex_muldiv = 1'b0;
            #1;
            vectors++;
            if (obs_ctrl() !== exp_ctrl()) begin
                miscompares++;
                $display("FAIL muldiv_ctrl cyc%0d: got %b want %b", i, obs_ctrl(), exp_ctrl());
            end
            if (!bus.pc_en) n_pc_low++;
            if (bus.md_busy) n_busy++;
            if (bus.md_start) n_start++;
            tick();
        end
        vectors++;
        if (n_pc_low != 8 || n_busy != 7 || n_start != 1) begin
            miscompares++;
            $display("FAIL muldiv_counts: got pc_low=%0d busy=%0d start=%0d want 8/7/1",
                     n_pc_low, n_busy, n_start);
        end
        vectors++;
        if (bus.stall_cnt !== 16'(s0 + 8)) begin
            miscompares++;
            $display("FAIL muldiv_stall_cnt: got %0d want %0d", bus.stall_cnt, s0 + 8);
        end
    endtask

    task automatic test_branch_priority();
        int s0;
        s0 = m_stall;
        bus.id_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd7; bus.id_rt = 5'd7;
        bus.ex_branch_taken = 1'b1;
        #1;
        vectors++;
        if (obs_ctrl() !== CtlSquash) begin
            miscompares++;
            $display("FAIL branch_ctrl: got %b want %b", obs_ctrl(), CtlSquash);
        end
        tick();
        bus.ex_branch_taken = 1'b0; bus.ex_jump = 1'b1;
        #1;
        vectors++;
        if (obs_ctrl() !== CtlSquash) begin
            miscompares++;
            $display("FAIL jump_ctrl: got %b want %b", obs_ctrl(), CtlSquash);
        end
        tick();
        vectors++;
        if (bus.stall_cnt !== 16'(s0)) begin
            miscompares++;
            $display("FAIL branch_stall_cnt: got %0d want %0d", bus.stall_cnt, s0);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_busy();
        idle_inputs();
        bus.ex_muldiv = 1'b1;
        #1;
        tick();
        bus.ex_muldiv = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        // Fourth MD_BUSY cycle
        #1;
        vectors++;
        if (bus.md_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_busy_pre: got md_busy=%b want 1", bus.md_busy);
        end
        reset = 1'b1;
        #1;
        tick();
        reset = 1'b0;
        #1;
        vectors++;
        if (obs_ctrl() !== CtlIdle || bus.stall_cnt !== 16'd0 || bus4.stall_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL mid_busy_reset: got %b/%0d/%0d want %b/0/0", obs_ctrl(),
                     bus.stall_cnt, bus4.stall_cnt, CtlIdle);
        end
    endtask

    task automatic test_saturation();
        idle_inputs();
        bus.id_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd9; bus.id_rs = 5'd9;
        for (int i = 0; i < 20; i++) begin
            #1;
            tick();
            vectors++;
            if (bus4.stall_cnt !== sat4(m_stall) || bus.stall_cnt !== sat16(m_stall)) begin
                miscompares++;
                $display("FAIL sat_cnt cyc%0d: got %0d/%0d want %0d/%0d", i, bus4.stall_cnt,
                         bus.stall_cnt, sat4(m_stall), sat16(m_stall));
            end
        end
        vectors++;
        if (bus4.stall_cnt !== 4'd15) begin
            miscompares++;
            $display("FAIL sat_final: got %0d want 15", bus4.stall_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        bus.ex_muldiv = 1'b1;
        for (int i = 0; i < 2 * MdLat + 2; i++) begin
            #1;
            vectors++;
            if (obs_ctrl() !== exp_ctrl()) begin
                miscompares++;
                $display("FAIL b2b_ctrl cyc%0d: got %b want %b", i, obs_ctrl(), exp_ctrl());
            end
            tick();
        end
        idle_inputs();
        for (int i = 0; i < MdLat; i++) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            random_inputs();
            reset = ($urandom_range(63) == 0);
            #1;
            vectors++;
            if (obs_ctrl() !== exp_ctrl()) begin
                miscompares++;
                $display("FAIL rand_ctrl cyc%0d: got %b want %b", i, obs_ctrl(), exp_ctrl());
            end
            tick();
            vectors++;
            if (bus.stall_cnt !== sat16(m_stall) || bus4.stall_cnt !== sat4(m_stall)) begin
                miscompares++;
                $display("FAIL rand_cnt cyc%0d: got %0d/%0d want %0d/%0d", i, bus.stall_cnt,
                         bus4.stall_cnt, sat16(m_stall), sat4(m_stall));
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_muldiv();
        test_branch_priority();
        test_back_to_back();
        test_reset_mid_busy();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipelined MIPS core. It sits beside the decoder and per-stage pipeline registers. It detects load-use hazards, squashes wrong-path instructions on taken branches and jumps, and sequences the multi-cycle mult/div unit by freezing the front end while it runs. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
MD_LAT, 8, mult/div execution latency in cycles (legal range 2..255)
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high
id_valid  input  1  ID stage holds a real instruction
id_rs  input  5  rs field of the instruction in ID
id_rt  input  5  rt field of the instruction in ID
ex_mem_read  input  1  instruction in EX is lw
ex_rt  input  5  destination rt of the instruction in EX
ex_muldiv  input  1  instruction in EX is mult/div (R-type, opcode 000000)
ex_branch_taken  input  1  beq in EX resolved taken
ex_jump  input  1  instruction in EX is j
pc_en  output  1  PC register load enable
ifid_en  output  1  IF/ID register load enable
ifid_flush  output  1  clear IF/ID to a nop
idex_en  output  1  ID/EX register load enable
idex_flush  output  1  load a bubble (all control zero) into ID/EX
exmem_flush  output  1  load a bubble into EX/MEM
md_start  output  1  one-cycle start pulse to the mult/div unit
md_busy  output  1  mult/div sequence in progress
stall_cnt  output  CNT_W  saturating count of front-end stall cycles

Behaviour:
- State register with states RUN and MD_BUSY. An 8-bit down-counter md_cnt and stall_cnt are registered. All other outputs are Mealy functions of state and current inputs.
- Reset (any cycle, including mid MD_BUSY): next state RUN, md_cnt=0, stall_cnt=0.
- Outputs while reset=1: pc_en=0, ifid_en=0, ifid_flush=1, idex_en=1, idex_flush=1, exmem_flush=1, md_start=0, md_busy=0.
- Default in RUN with no event: pc_en=1, ifid_en=1, idex_en=1, all flushes=0, md_start=0, md_busy=0.
- Priority in RUN, highest first: mult/div, then branch/jump, then load-use.
- Mult/div (RUN, ex_muldiv=1):
  - md_start=1 for exactly this cycle.
  - pc_en=0, ifid_en=0, idex_en=0, exmem_flush=1.
  - Next state MD_BUSY; md_cnt loads MD_LAT-2.
- MD_BUSY:
  - md_busy=1, pc_en=0, ifid_en=0, idex_en=0, exmem_flush=1; all hazard inputs ignored.
  - md_cnt decrements each cycle. In the cycle md_cnt==0: exmem_flush=0, idex_en=1, next state RUN.
  - Total front-end freeze is exactly MD_LAT cycles, counting the md_start cycle.
  - The mult/div result reaches EX/MEM on the final MD_BUSY cycle.
- Branch/jump (RUN, ex_branch_taken=1 or ex_jump=1, ex_muldiv=0):
  - pc_en=1 (redirect target loads), ifid_flush=1, idex_flush=1.
  - This is a 2-instruction squash and costs no stall cycle. Load-use is suppressed in the same cycle because the ID instruction is discarded.
- Load-use (RUN, no higher event): hazard = id_valid & ex_mem_read & (ex_rt!=0) & (ex_rt==id_rs | ex_rt==id_rt).
  - When hazard=1: pc_en=0, ifid_en=0, idex_flush=1.
  - Lasts one cycle, because the lw advances to MEM and the bubble now sits in EX.
- stall_cnt increments by 1 on every non-reset cycle with pc_en=0 (load-use, mult/div start and MD_BUSY). It saturates at all ones and does not wrap. Flush-only cycles do not count.
- ex_muldiv is sampled only in RUN. A held-high ex_muldiv after return to RUN is a new operation; the ID/EX update on the exit cycle guarantees a new instruction in EX.
- Register $0 never causes a hazard.

Test Plan:
- Reset for 3 cycles, release -> outputs follow reset values during reset. First cycle after release: pc_en=1, ifid_en=1, all flushes=0, stall_cnt=0.
- lw with ex_rt=5, id_rs=5, id_valid=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1, then normal; stall_cnt=1. Repeat with ex_rt=0 -> no stall.
- ex_muldiv=1 with MD_LAT=8 -> md_start high 1 cycle, pc_en low exactly 8 cycles, md_busy high 7 cycles, then RUN; stall_cnt=8.
- ex_branch_taken=1 together with a load-use match -> ifid_flush=1, idex_flush=1, pc_en=1; no stall; stall_cnt unchanged.
- Assert reset on the 4th MD_BUSY cycle -> next cycle state RUN, md_busy=0, md_cnt=0, stall_cnt=0.
- CNT_W=4, 20 consecutive load-use stalls -> stall_cnt saturates at 15 and holds.
